// File: rtl/mat_pkg.sv
// Shared 3x3 matrix constants, element type, flat-word indexing helper and packer state encoding.
package mat_pkg;

    localparam int MAT_N      = 3;
    localparam int MAT_EW     = 3;
    localparam int MAT_NE     = MAT_N * MAT_N;
    localparam int MAT_FLAT_W = MAT_NE * MAT_EW;
    localparam int MAT_CW     = $clog2(MAT_NE);

    typedef logic [MAT_EW-1:0] elem_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    // Bit offset of element (r,c) inside the row-major flat word.
    function automatic int mat_idx(input int r, input int c);
        return (r * MAT_N + c) * MAT_EW;
    endfunction

endpackage

// File: rtl/mat_sym_check.sv
// Combinational check that a flat matrix is a valid adjacency matrix:
// symmetric off-diagonal entries and an all-zero diagonal.
module mat_sym_check
    import mat_pkg::*;
(
    input  logic [MAT_FLAT_W-1:0] flat_in,
    output logic                  sym_ok
);

    always_comb begin
        sym_ok = 1'b1;
        for (int r = 0; r < MAT_N; r++) begin
            for (int c = 0; c < MAT_N; c++) begin
                if (r == c) begin
                    if (flat_in[mat_idx(r, c) +: MAT_EW] != '0) sym_ok = 1'b0;
                end else if (r < c) begin
                    if (flat_in[mat_idx(r, c) +: MAT_EW] != flat_in[mat_idx(c, r) +: MAT_EW])
                        sym_ok = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_packer.sv
// Serial-to-flat assembler for NxN matrices: collects row-major elements, holds the packed frame
// until accepted. Optional adjacency check enabled by defining MATRIX_PACKER_SYMCHK_EN.
module matrix_packer
    import mat_pkg::*;
#(
    parameter int N  = MAT_N,
    parameter int EW = MAT_EW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW-1:0]       in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*EW-1:0]   flat_out,
    output logic                frame_err,
    output logic                sym_ok
);

    localparam int NE     = N * N;
    localparam int FLAT_W = NE * EW;
    localparam int CW     = $clog2(NE);

    localparam logic [0:0] ST_COLLECT = 1'(COLLECT);
    localparam logic [0:0] ST_FULL    = 1'(FULL);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [FLAT_W-1:0] flat_q, flat_d;
    logic              err_q, err_d;
    logic              last_slot;
    logic              enter_full;
    logic              release_full;

    assign last_slot    = (idx_q == CW'(NE - 1));
    assign enter_full   = (state_q == ST_COLLECT) && (state_d == ST_FULL);
    assign release_full = (state_q == ST_FULL) && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        flat_d  = flat_q;
        err_d   = err_q;
        if (clr) begin
            state_d = ST_COLLECT;
            idx_d   = '0;
            flat_d  = '0;
            err_d   = 1'b0;
        end else if (state_q == ST_COLLECT) begin
            if (in_valid) begin
                flat_d[idx_q*EW +: EW] = in_data;
                idx_d = idx_q + 1'b1;
                // Frame closes on either marker; a mismatch between the two is a framing error.
                if (in_last || last_slot) begin
                    state_d = ST_FULL;
                    err_d   = in_last ^ last_slot;
                end
            end
        end else if (out_ready) begin
            state_d = ST_COLLECT;
            idx_d   = '0;
            flat_d  = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            flat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flat_q  <= flat_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_FULL);
    assign flat_out  = flat_q;
    assign frame_err = err_q;

`ifdef MATRIX_PACKER_SYMCHK_EN
    logic sym_q, sym_d;
    logic sym_chk;

    // Checker looks at the frame being committed so the flag is valid together with out_valid.
    mat_sym_check u_sym_check (
        .flat_in (flat_d),
        .sym_ok  (sym_chk)
    );

    always_comb begin
        sym_d = sym_q;
        if (clr)               sym_d = 1'b0;
        else if (enter_full)   sym_d = sym_chk;
        else if (release_full) sym_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sym_q <= 1'b0;
        else     sym_q <= sym_d;
    end

    assign sym_ok = sym_q;
`else
    assign sym_ok = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_packer.sv
// Directed, table-driven bench for matrix_packer; sym_ok expectations follow MATRIX_PACKER_SYMCHK_EN.
module tb_matrix_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] flat_out;
    logic        frame_err;
    logic        sym_ok;

    always #5 clk = ~clk;

    matrix_packer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flat_out  (flat_out),
        .frame_err (frame_err),
        .sym_ok    (sym_ok)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [26:0] e;       // element i at bits [3i +: 3]
        int          n;       // elements to send
        int          last_at; // element carrying in_last, -1 for none
        logic [26:0] flat;
        logic        err;
        logic        sym;
    } vec_t;

    vec_t vt[8];

    function automatic vec_t mk(input logic [26:0] e, input int n, input int last_at,
                                input logic [26:0] flat, input logic err, input logic sym);
        vec_t v;
        v.e = e; v.n = n; v.last_at = last_at; v.flat = flat; v.err = err; v.sym = sym;
        return v;
    endfunction

    function automatic logic sym_exp(input logic s);
`ifdef MATRIX_PACKER_SYMCHK_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0o%0o, expected 0o%0o", name, act, exp);
        end
    endtask

    task automatic send_elem(input logic [2:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_handshake", 32'(in_ready), 32'd1);
        check("out_valid_while_collecting", 32'(out_valid), 32'd0);
        @(posedge clk);
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) send_elem(v.e[3*i +: 3], logic'(i == v.last_at));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_full(input string tag, input logic [26:0] flat, input logic err,
                              input logic sym);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".flat_out"},  32'(flat_out),  32'(flat));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(err));
        check({tag, ".sym_ok"},    32'(sym_ok),    32'(sym_exp(sym)));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".flat_out"},  32'(flat_out),  32'd0);
        check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
        check({tag, ".sym_ok"},    32'(sym_ok),    32'd0);
    endtask

    task automatic accept_frame(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_idle({tag, ".after_accept"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(27'o107654321, 9,  8, 27'o107654321, 1'b0, 1'b0);
        vt[1] = mk(27'o000000777, 3,  2, 27'o000000777, 1'b1, 1'b0);
        vt[2] = mk(27'o000000000, 9,  8, 27'o000000000, 1'b0, 1'b1);
        vt[3] = mk(27'o000000010, 9,  8, 27'o000000010, 1'b0, 1'b0);
        vt[4] = mk(27'o000001010, 9,  8, 27'o000001010, 1'b0, 1'b1);
        vt[5] = mk(27'o300000000, 9,  8, 27'o300000000, 1'b0, 1'b0);
        vt[6] = mk(27'o555555555, 9, -1, 27'o555555555, 1'b1, 1'b0);
        vt[7] = mk(27'o000000005, 1,  0, 27'o000000005, 1'b1, 1'b0);

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // Table: each frame is presented back-to-back and accepted on the first full cycle.
        for (int t = 0; t < 8; t++) begin
            send_frame(vt[t]);
            check_full($sformatf("vec%0d", t), vt[t].flat, vt[t].err, vt[t].sym);
            accept_frame($sformatf("vec%0d", t));
        end

        // Backpressure: FULL held five cycles while the source keeps offering data.
        send_frame(vt[0]);
        for (int k = 0; k < 5; k++) begin
            check_full($sformatf("hold%0d", k), vt[0].flat, 1'b0, 1'b0);
            in_valid = 1'b1;
            in_data  = 3'd6;
            @(negedge clk);
        end
        out_ready = 1'b1;
        check_full("hold5", vt[0].flat, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_idle("hold_release");
        send_frame(vt[2]);
        check_full("after_hold", 27'o0, 1'b0, 1'b1);
        accept_frame("after_hold");

        // Missing in_last: the tenth element starts a fresh frame at idx 0.
        send_frame(vt[6]);
        check_full("nolast", 27'o555555555, 1'b1, 1'b0);
        accept_frame("nolast");
        send_elem(3'd3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_full("tenth", 27'o000000003, 1'b1, 1'b0);
        accept_frame("tenth");

        // Async reset mid-frame.
        for (int i = 0; i < 4; i++) send_elem(3'(i + 1), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("partial.flat_out", 32'(flat_out), 32'o4321);
        #2 rst = 1'b1;
        #1 check_idle("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        send_frame(vt[0]);
        check_full("post_rst_frame", vt[0].flat, 1'b0, 1'b0);
        accept_frame("post_rst_frame");

        // clr mid-frame, coinciding with an offered last element to show its priority.
        for (int i = 0; i < 4; i++) send_elem(3'd7, 1'b0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 3'd5; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_idle("after_clr");
        send_frame(vt[0]);
        check_full("post_clr_frame", vt[0].flat, 1'b0, 1'b0);
        accept_frame("post_clr_frame");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
